matmul_ctrl_regfile: RTL and testbench

APB-slave control/status register file for the matrix-multiply accelerator; the parametrised successor of the single control register.
- Holds the operation configuration and issues a one-cycle start pulse to the compute engine.
- Tracks engine progress in an IDLE/BUSY/DONE state machine with sticky done/error status and a busy-cycle counter.
- Rejects illegal accesses with pslverr.

---
 rtl/matmul_pkg.sv | 26 ++
 rtl/matmul_ctrl_regfile_apb.sv | 24 ++
 rtl/matmul_ctrl_regfile.sv | 149 ++++++++++++++
 tb/tb_matmul_ctrl_regfile.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply control/status register file.
package matmul_pkg;

    // Register byte offsets
    localparam int unsigned CTRL_ADDR   = 'h0;
    localparam int unsigned STATUS_ADDR = 'h4;
    localparam int unsigned CYCLES_ADDR = 'h8;

    // CTRL bit positions that the control logic looks at directly
    localparam int CTRL_START = 0;

    // Dataflow encoding that the engine does not support
    localparam logic [1:0] DF_RESERVED = 2'b11;

    // STATUS bit indices
    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_ERR  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/matmul_ctrl_regfile_apb.sv
// Zero-wait-state APB access-phase decode: qualifies reads/writes and
// reduces the byte address to a word index.
module apb_slave_if #(
    parameter int ADDR_W = 4
) (
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    output logic              pready,
    output logic              wr_en,
    output logic              rd_en,
    output logic [ADDR_W-3:0] word_addr
);

    logic unused_byte_lanes;

    assign pready            = psel & penable;
    assign wr_en             = pready & pwrite;
    assign rd_en             = pready & ~pwrite;
    assign word_addr         = paddr[ADDR_W-1:2];
    assign unused_byte_lanes = &{1'b0, paddr[1:0]};

endmodule

// File: rtl/matmul_ctrl_regfile.sv
// Control/status register file for the matrix-multiply accelerator.
//
// state | meaning
// IDLE  | no operation outstanding
// BUSY  | engine running, busy-cycle counter advancing
// DONE  | engine finished; done flag visible until cleared or restarted
module matmul_ctrl_regfile
    import matmul_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int DIM_W  = 2,
    parameter int CYC_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              psel_i,
    input  logic              penable_i,
    input  logic              pwrite_i,
    input  logic [ADDR_W-1:0] paddr_i,
    input  logic [DATA_W-1:0] pwdata_i,
    output logic [DATA_W-1:0] prdata_o,
    output logic              pready_o,
    output logic              pslverr_o,
    input  logic              engine_done_i,
    output logic              start_o,
    output logic              busy_o,
    output logic              cfg_mode_o,
    output logic [1:0]        cfg_write_target_o,
    output logic [1:0]        cfg_read_target_o,
    output logic [1:0]        cfg_dataflow_o,
    output logic [DIM_W-1:0]  cfg_dim_n_o,
    output logic [DIM_W-1:0]  cfg_dim_k_o,
    output logic [DIM_W-1:0]  cfg_dim_m_o,
    output logic              cfg_reload_a_o,
    output logic              cfg_reload_b_o
);

    localparam int CTRL_W = 10 + 3 * DIM_W;
    localparam logic [ADDR_W-3:0] CTRL_WORD   = (ADDR_W-2)'(CTRL_ADDR >> 2);
    localparam logic [ADDR_W-3:0] STATUS_WORD = (ADDR_W-2)'(STATUS_ADDR >> 2);
    localparam logic [ADDR_W-3:0] CYCLES_WORD = (ADDR_W-2)'(CYCLES_ADDR >> 2);

    state_t             state, state_nxt;
    logic [CTRL_W-1:0]  ctrl;
    logic [CYC_W-1:0]   cycles;
    logic               err_sticky;
    logic               start_q;

    logic               wr_en, rd_en;
    logic [ADDR_W-3:0]  word_addr;
    logic               hit_ctrl, hit_status, hit_cycles, hit_none;
    logic               ctrl_wr, ctrl_rej, ctrl_ok, start_acc;
    logic               done_clr, err_clr;
    logic               unused_wdata;

    apb_slave_if #(.ADDR_W(ADDR_W)) u_apb (
        .psel      (psel_i),
        .penable   (penable_i),
        .pwrite    (pwrite_i),
        .paddr     (paddr_i),
        .pready    (pready_o),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .word_addr (word_addr)
    );

    assign hit_ctrl   = (word_addr == CTRL_WORD);
    assign hit_status = (word_addr == STATUS_WORD);
    assign hit_cycles = (word_addr == CYCLES_WORD);
    assign hit_none   = ~(hit_ctrl | hit_status | hit_cycles);

    // CTRL is frozen while the engine runs, and the reserved dataflow is never loaded
    assign ctrl_wr   = wr_en & hit_ctrl;
    assign ctrl_rej  = ctrl_wr & ((state == BUSY) | (pwdata_i[7:6] == DF_RESERVED));
    assign ctrl_ok   = ctrl_wr & ~ctrl_rej;
    assign start_acc = ctrl_ok & pwdata_i[CTRL_START];
    assign done_clr  = wr_en & hit_status & pwdata_i[STAT_DONE];
    assign err_clr   = wr_en & hit_status & pwdata_i[STAT_ERR];

    assign pslverr_o    = pready_o & (hit_none | ctrl_rej);
    assign unused_wdata = &{1'b0, pwdata_i[DATA_W-1:CTRL_W]};

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; engine_done_i only matters while BUSY
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start_acc) state_nxt = BUSY;
            BUSY:    if (engine_done_i) state_nxt = DONE;
            DONE: begin
                if (start_acc)     state_nxt = BUSY;
                else if (done_clr) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Configuration, sticky error, start pulse and saturating busy-cycle counter
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ctrl       <= '0;
            err_sticky <= 1'b0;
            start_q    <= 1'b0;
            cycles     <= '0;
        end else begin
            start_q <= start_acc;
            if (ctrl_ok) ctrl <= {pwdata_i[CTRL_W-1:1], 1'b0};
            if (ctrl_rej)     err_sticky <= 1'b1;
            else if (err_clr) err_sticky <= 1'b0;
            if (start_acc) cycles <= '0;
            else if ((state == BUSY) && (cycles != '1)) cycles <= cycles + CYC_W'(1);
        end
    end

    // Read mux; data only driven during a read access phase to a mapped register
    always_comb begin
        prdata_o = '0;
        if (rd_en) begin
            if (hit_ctrl) begin
                prdata_o = DATA_W'(ctrl);
            end else if (hit_status) begin
                prdata_o[STAT_BUSY] = (state == BUSY);
                prdata_o[STAT_DONE] = (state == DONE);
                prdata_o[STAT_ERR]  = err_sticky;
            end else if (hit_cycles) begin
                prdata_o = DATA_W'(cycles);
            end
        end
    end

    assign start_o            = start_q;
    assign busy_o             = (state == BUSY);
    assign cfg_mode_o         = ctrl[1];
    assign cfg_write_target_o = ctrl[3:2];
    assign cfg_read_target_o  = ctrl[5:4];
    assign cfg_dataflow_o     = ctrl[7:6];
    assign cfg_dim_n_o        = ctrl[8 +: DIM_W];
    assign cfg_dim_k_o        = ctrl[8 + DIM_W +: DIM_W];
    assign cfg_dim_m_o        = ctrl[8 + 2*DIM_W +: DIM_W];
    assign cfg_reload_a_o     = ctrl[8 + 3*DIM_W];
    assign cfg_reload_b_o     = ctrl[9 + 3*DIM_W];

endmodule

// File: tb/tb_matmul_ctrl_regfile.sv
// Bench for the matmul control/status register file: directed walk through
// the main scenarios followed by random APB traffic and engine_done pulses.
module tb_matmul_ctrl_regfile;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 4;
    localparam int DIM_W   = 2;
    localparam int CYC_W   = 3;
    localparam int CYC_MAX = (1 << CYC_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [ADDR_W-1:0] paddr = '0;
    logic [DATA_W-1:0] pwdata = '0;
    logic              engine_done = 1'b0;
    logic [DATA_W-1:0] prdata;
    logic              pready, pslverr, start, busy;
    logic              cfg_mode, cfg_reload_a, cfg_reload_b;
    logic [1:0]        cfg_write_target, cfg_read_target, cfg_dataflow;
    logic [DIM_W-1:0]  cfg_dim_n, cfg_dim_k, cfg_dim_m;
    logic [15:0]       cfg_word;

    always #5 clk = ~clk;

    matmul_ctrl_regfile #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DIM_W(DIM_W), .CYC_W(CYC_W)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .psel_i             (psel),
        .penable_i          (penable),
        .pwrite_i           (pwrite),
        .paddr_i            (paddr),
        .pwdata_i           (pwdata),
        .prdata_o           (prdata),
        .pready_o           (pready),
        .pslverr_o          (pslverr),
        .engine_done_i      (engine_done),
        .start_o            (start),
        .busy_o             (busy),
        .cfg_mode_o         (cfg_mode),
        .cfg_write_target_o (cfg_write_target),
        .cfg_read_target_o  (cfg_read_target),
        .cfg_dataflow_o     (cfg_dataflow),
        .cfg_dim_n_o        (cfg_dim_n),
        .cfg_dim_k_o        (cfg_dim_k),
        .cfg_dim_m_o        (cfg_dim_m),
        .cfg_reload_a_o     (cfg_reload_a),
        .cfg_reload_b_o     (cfg_reload_b)
    );

    assign cfg_word = {cfg_reload_b, cfg_reload_a, cfg_dim_m, cfg_dim_k, cfg_dim_n,
                       cfg_dataflow, cfg_read_target, cfg_write_target, cfg_mode, 1'b0};

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    resp_t sb_q[$];
    int    errors = 0;
    int    checks = 0;

    // Reference model: 0 idle, 1 running, 2 finished
    int          m_st = 0;
    logic [15:0] m_ctrl = '0;
    bit          m_err = 0;
    int          m_cyc = 0;
    bit          m_start = 0;

    bit          exp_busy, exp_start, exp_ready;
    logic [15:0] exp_cfg;
    bit          mon_on = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: per-cycle output checks plus scoreboard pop on every completed access
    always @(negedge clk) begin
        if (mon_on) begin
            resp_t r;
            check("busy_o", busy, exp_busy);
            check("start_o", start, exp_start);
            check("cfg", cfg_word, exp_cfg);
            check("pready_o", pready, exp_ready);
            if (pready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard at %0t: access completed with no expectation queued", $time);
                end else begin
                    r = sb_q.pop_front();
                    check("prdata_o", prdata, r.rdata);
                    check("pslverr_o", pslverr, r.err);
                end
            end else begin
                check("idle_prdata", prdata, 32'h0);
                check("idle_pslverr", pslverr, 1'b0);
            end
        end
    end

    // Drive one clock cycle of inputs, publish the model's expectations for it,
    // then advance the model across the closing clock edge.
    task automatic do_cycle(input bit r, input bit s, input bit en, input bit wr,
                            input logic [3:0] a, input logic [31:0] d, input bit ed);
        bit acc, bad, cwr, crej, ok, start_now, st_wr;
        logic [1:0] w;
        resp_t e;
        int nst;
        rst = r; psel = s; penable = en; pwrite = wr; paddr = a; pwdata = d; engine_done = ed;
        if (r) begin
            m_st = 0; m_ctrl = '0; m_err = 0; m_cyc = 0; m_start = 0;
        end
        acc   = s && en;
        w     = a[3:2];
        bad   = (w == 2'd3);
        cwr   = acc && wr && (w == 2'd0);
        crej  = cwr && ((m_st == 1) || (d[7:6] == 2'b11));
        ok    = cwr && !crej;
        st_wr = acc && wr && (w == 2'd1);
        exp_busy  = (m_st == 1);
        exp_start = m_start;
        exp_cfg   = m_ctrl;
        exp_ready = acc;
        if (acc) begin
            e.err   = bad || crej;
            e.rdata = '0;
            if (!wr && !bad) begin
                case (w)
                    2'd0: e.rdata = {16'h0, m_ctrl};
                    2'd1: e.rdata = {29'h0, m_err, (m_st == 2), (m_st == 1)};
                    default: e.rdata = m_cyc;
                endcase
            end
            sb_q.push_back(e);
        end
        @(posedge clk);
        if (!r) begin
            start_now = ok && d[0];
            if (ok) m_ctrl = d[15:0] & 16'hFFFE;
            if (crej) m_err = 1;
            else if (st_wr && d[2]) m_err = 0;
            nst = m_st;
            case (m_st)
                0: if (start_now) nst = 1;
                1: begin
                    if (m_cyc < CYC_MAX) m_cyc++;
                    if (ed) nst = 2;
                end
                default: begin
                    if (start_now) nst = 1;
                    else if (st_wr && d[1]) nst = 0;
                end
            endcase
            if (start_now) m_cyc = 0;
            m_st    = nst;
            m_start = start_now;
        end
        #1;
    endtask

    task automatic apb(input bit wr, input logic [3:0] a, input logic [31:0] d, input bit ed);
        do_cycle(0, 1, 0, wr, a, d, 0);
        do_cycle(0, 1, 1, wr, a, d, ed);
    endtask

    task automatic idle(input int n, input bit ed_last);
        for (int i = 0; i < n; i++) do_cycle(0, 0, 0, 0, 4'h0, 32'h0, ed_last && (i == n - 1));
    endtask

    task automatic reset_for(input int n);
        for (int i = 0; i < n; i++) do_cycle(1, 0, 0, 0, 4'h0, 32'h0, 0);
    endtask

    initial begin
        int unsigned sel;
        logic [31:0] d;
        logic [3:0]  a;

        @(posedge clk);
        #1;
        mon_on = 1;

        // Reset state
        reset_for(2);
        idle(1, 0);
        apb(0, 4'h0, 32'h0, 0);
        apb(0, 4'h4, 32'h0, 0);
        apb(0, 4'h8, 32'h0, 0);

        // Start, five busy cycles with done on the fifth
        apb(1, 4'h0, 32'h0000_1541, 0);
        idle(4, 0);
        idle(1, 1);
        apb(0, 4'h4, 32'h0, 0);
        apb(0, 4'h8, 32'h0, 0);

        // Restart from DONE, reject a CTRL write while busy, clear the error
        apb(1, 4'h0, 32'h0000_1541, 0);
        apb(1, 4'h0, 32'h0000_00A2, 0);
        apb(0, 4'h4, 32'h0, 0);
        apb(1, 4'h4, 32'h0000_0004, 0);
        apb(0, 4'h4, 32'h0, 0);
        // CTRL write coincident with engine_done: rejected, still reaches DONE
        apb(1, 4'h0, 32'h0000_0022, 1);
        apb(0, 4'h4, 32'h0, 0);

        // Clear done -> IDLE, clear error, reserved dataflow, unmapped address
        apb(1, 4'h4, 32'h0000_0002, 0);
        apb(1, 4'h4, 32'h0000_0004, 0);
        apb(0, 4'h4, 32'h0, 0);
        apb(1, 4'h0, 32'h0000_00C1, 0);
        idle(2, 0);
        apb(0, 4'hC, 32'h0, 0);
        apb(1, 4'hD, 32'hFFFF_FFFF, 0);
        apb(0, 4'h4, 32'h0, 0);
        apb(1, 4'h4, 32'h0000_0004, 0);

        // Counter saturation
        apb(1, 4'h0, 32'h0000_3F55, 0);
        idle(10, 0);
        apb(0, 4'h8, 32'h0, 0);

        // Reset mid-operation, then a stray done pulse
        reset_for(1);
        idle(2, 0);
        apb(1, 4'h0, 32'h0000_1541, 0);
        idle(2, 0);
        reset_for(2);
        idle(1, 1);
        apb(0, 4'h4, 32'h0, 0);
        apb(0, 4'h0, 32'h0, 0);

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            sel = $urandom_range(0, 19);
            d   = $urandom;
            a   = 4'($urandom);
            if (sel < 7) begin
                if ($urandom_range(0, 3) != 0) d[7:6] = 2'($urandom_range(0, 2));
                if ($urandom_range(0, 1) == 0) a[3:2] = 2'($urandom_range(0, 1));
                apb(1, a, d, $urandom_range(0, 3) == 0);
            end else if (sel < 12) begin
                apb(0, a, 32'h0, $urandom_range(0, 3) == 0);
            end else if (sel < 19) begin
                for (int j = 0, n = $urandom_range(1, 6); j < n; j++)
                    do_cycle(0, 0, 0, 0, 4'h0, 32'h0, $urandom_range(0, 3) == 0);
            end else begin
                reset_for(1);
            end
        end
        idle(2, 0);

        mon_on = 0;
        check("sb_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
